// File: rtl/seq_vedic_mul.sv
// Sequential NxN unsigned multiplier built around a single 2x2 Vedic cell.
// One digit pair is multiplied per cycle and the shifted products are accumulated.

module twoxtwo_mul (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic t1, t2, t3, c1;

    assign t1   = a[1] & b[0];
    assign t2   = a[0] & b[1];
    assign t3   = a[1] & b[1];
    assign c1   = t1 & t2;
    assign p[0] = a[0] & b[0];
    assign p[1] = t1 ^ t2;
    assign p[2] = t3 ^ c1;
    assign p[3] = t3 & c1;
endmodule

module seq_vedic_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);
    localparam int D  = WIDTH / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc, acc_next, pp_ext;
    logic [IW-1:0]      i, j;
    logic [1:0]         da, db;
    logic [3:0]         pp;
    logic               last;

    twoxtwo_mul u_cell (
        .a (da),
        .b (db),
        .p (pp)
    );

    always_comb begin
        da       = 2'(a_r >> (2 * i));
        db       = 2'(b_r >> (2 * j));
        pp_ext   = {{(2*WIDTH-4){1'b0}}, pp};
        acc_next = acc + (pp_ext << (2 * (i + j)));
        last     = (i == LAST) && (j == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            a_r     <= '0;
            b_r     <= '0;
        end else begin
            case (state)
                RUN: begin
                    acc  <= acc_next;
                    done <= 1'b0;
                    if (j == LAST) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                    if (last) begin
                        product <= acc_next;
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                // IDLE and DONE both accept a new request
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_vedic_mul.sv
// Directed bench for seq_vedic_mul at WIDTH=4 and WIDTH=8.
// Inputs driven and outputs sampled on the falling edge.

module tb_seq_vedic_mul;
    logic        clk = 1'b0;
    logic        rst;
    logic        s4, s8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic        busy4, done4, busy8, done8;
    int          nvec = 0;
    int          nerr = 0;
    int          lat;

    always #5 clk = ~clk;

    seq_vedic_mul #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (s4),
        .a       (a4),
        .b       (b4),
        .product (p4),
        .busy    (busy4),
        .done    (done4)
    );

    seq_vedic_mul #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (s8),
        .a       (a8),
        .b       (b8),
        .product (p8),
        .busy    (busy8),
        .done    (done8)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns the number of falling edges from start to done (40 = timeout)
    task automatic run4(input logic [3:0] x, input logic [3:0] y,
                        output int l);
        a4 = x;
        b4 = y;
        s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        l  = 1;
        while (!done4 && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        output int l);
        a8 = x;
        b8 = y;
        s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        l  = 1;
        while (!done8 && l < 60) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        rst = 1'b1;
        s4  = 1'b0;
        s8  = 1'b0;
        a4  = '0;
        b4  = '0;
        a8  = '0;
        b8  = '0;
        repeat (2) @(negedge clk);
        chk("rst_p4", 32'(p4), 0);
        chk("rst_busy4", 32'(busy4), 0);
        chk("rst_done4", 32'(done4), 0);
        chk("rst_p8", 32'(p8), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 3*5 with cycle-accurate busy/done
        a4 = 4'd3;
        b4 = 4'd5;
        s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_busy", 32'(busy4), 1);
            chk("t1_nodone", 32'(done4), 0);
            chk("t1_hold", 32'(p4), 0);
            @(negedge clk);
        end
        chk("t1_done", 32'(done4), 1);
        chk("t1_busy_lo", 32'(busy4), 0);
        chk("t1_prod", 32'(p4), 15);
        @(negedge clk);
        chk("t1_pulse", 32'(done4), 0);
        chk("t1_keep", 32'(p4), 15);

        // 2: corners then exhaustive sweep
        run4(4'd15, 4'd15, lat);
        chk("t2_lat", 32'(lat), 5);
        chk("t2_225", 32'(p4), 225);
        @(negedge clk);
        run4(4'd0, 4'd13, lat);
        chk("t2_zero", 32'(p4), 0);
        @(negedge clk);
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run4(4'(x), 4'(y), lat);
                chk("sweep_lat", 32'(lat), 5);
                chk("sweep", 32'(p4), 32'(x * y));
            end
        end
        @(negedge clk);

        // 3: start and operand changes ignored during RUN
        a4 = 4'd6;
        b4 = 4'd7;
        s4 = 1'b1;
        @(negedge clk);
        a4 = 4'd9;
        b4 = 4'd9;
        for (int k = 0; k < 4; k++) begin
            chk("t3_busy", 32'(busy4), 1);
            chk("t3_nodone", 32'(done4), 0);
            @(negedge clk);
        end
        chk("t3_done", 32'(done4), 1);
        chk("t3_prod", 32'(p4), 42);
        @(negedge clk);
        s4 = 1'b0;
        chk("t3_rerun", 32'(busy4), 1);
        lat = 1;
        while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t3_lat2", 32'(lat), 5);
        chk("t3_prod2", 32'(p4), 81);
        @(negedge clk);

        // 4: start held high -> one result per 5 cycles
        a4 = 4'd2;
        b4 = 4'd3;
        s4 = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk("t4_done", 32'(done4), (c % 5 == 0) ? 1 : 0);
            chk("t4_busy", 32'(busy4), (c % 5 == 0) ? 0 : 1);
            if (c % 5 == 0)
                chk("t4_prod", 32'(p4), 6);
        end
        s4 = 1'b0;
        @(negedge clk);
        chk("t4_idle", 32'(busy4), 0);

        // 5: reset aborts a run
        run4(4'd6, 4'd7, lat);
        chk("t5_prior", 32'(p4), 42);
        @(negedge clk);
        a4 = 4'd10;
        b4 = 4'd11;
        s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        @(negedge clk);
        chk("t5_busy_pre", 32'(busy4), 1);
        rst = 1'b1;
        #1;
        chk("t5_prod", 32'(p4), 0);
        chk("t5_busy", 32'(busy4), 0);
        chk("t5_done", 32'(done4), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t5_nopulse", 32'(done4), 0);
        end
        run4(4'd10, 4'd11, lat);
        chk("t5_lat", 32'(lat), 5);
        chk("t5_110", 32'(p4), 110);
        @(negedge clk);

        // 6: WIDTH=8
        run8(8'd255, 8'd255, lat);
        chk("t6_lat", 32'(lat), 17);
        chk("t6_max", 32'(p8), 65025);
        @(negedge clk);
        run8(8'd128, 8'd2, lat);
        chk("t6_256", 32'(p8), 256);
        @(negedge clk);
        run8(8'd200, 8'd100, lat);
        chk("t6_20000", 32'(p8), 20000);
        @(negedge clk);
        run8(8'h5A, 8'hA5, lat);
        chk("t6_14850", 32'(p8), 14850);
        @(negedge clk);
        run8(8'd1, 8'd0, lat);
        chk("t6_zero", 32'(p8), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
